// File: rtl/deser_pkg.sv
// Shared types and width helpers for the self-test link frame receiver.
package deser_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      RECV   = 2'd1,
      PARITY = 2'd2
   } state_e;

   // Counter width for a range of n values, never narrower than one bit.
   function automatic int width_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_sync_detect.sv
// Sliding SYNC_W-bit window over the serial stream, newest bit at LSB, with pattern compare.
module frame_sync_detect
   import deser_pkg::*;
#(
   parameter int                SYNC_W       = 4,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1010
) (
   input  logic t_clk,
   input  logic rst_n,
   input  logic shift_en,
   input  logic bit_in,
   input  logic clr,
   output logic match
);

   logic [SYNC_W-1:0] window_q, window_d;
   logic [SYNC_W-1:0] shifted;

   always_comb begin
      shifted  = SYNC_W'({window_q, bit_in});
      window_d = window_q;
      if (clr) begin
         window_d = '0;
      end else if (shift_en) begin
         window_d = shifted;
      end
      // Match is judged on the window as it will be after this bit, so overlaps work.
      match = shift_en && !clr && (shifted == SYNC_PATTERN);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n) begin
         window_q <= '0;
      end else begin
         window_q <= window_d;
      end
   end

endmodule

// File: rtl/frame_deserializer.sv
// Serial-to-parallel frame receiver: hunts for sync, assembles words, checks even parity.
module frame_deserializer
   import deser_pkg::*;
#(
   parameter int                DATA_W          = 8,
   parameter int                WORDS_PER_FRAME = 4,
   parameter int                SYNC_W          = 4,
   parameter logic [SYNC_W-1:0] SYNC_PATTERN    = 4'b1010,
   parameter bit                MSB_FIRST       = 1'b1,
   parameter bit                PARITY_EN       = 1'b1
) (
   input  logic                                  t_clk,
   input  logic                                  rst_n,
   input  logic                                  data_in,
   input  logic                                  bit_en,
   input  logic                                  sync_clr,
   output logic [DATA_W-1:0]                     data_out,
   output logic                                  data_valid,
   output logic [width_for(WORDS_PER_FRAME)-1:0] word_idx,
   output logic                                  frame_done,
   output logic                                  parity_err,
   output logic                                  busy
);

   localparam int CNT_W = width_for(DATA_W);
   localparam int IDX_W = width_for(WORDS_PER_FRAME);

   state_e              state_q,      state_d;
   logic [CNT_W-1:0]    bit_cnt_q,    bit_cnt_d;
   logic [IDX_W-1:0]    word_cnt_q,   word_cnt_d;
   logic [DATA_W-1:0]   shreg_q,      shreg_d;
   logic                xor_q,        xor_d;
   logic [DATA_W-1:0]   data_out_q,   data_out_d;
   logic                data_valid_q, data_valid_d;
   logic [IDX_W-1:0]    word_idx_q,   word_idx_d;
   logic                frame_done_q, frame_done_d;
   logic                parity_err_q, parity_err_d;

   logic                sync_match;
   logic [DATA_W-1:0]   word_next;

   // Window only runs while hunting; holding it cleared elsewhere keeps frame bits out of the next sync.
   frame_sync_detect #(
      .SYNC_W       (SYNC_W),
      .SYNC_PATTERN (SYNC_PATTERN)
   ) u_sync (
      .t_clk    (t_clk),
      .rst_n    (rst_n),
      .shift_en (bit_en && (state_q == HUNT)),
      .bit_in   (data_in),
      .clr      (sync_clr || (state_q != HUNT)),
      .match    (sync_match)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      word_cnt_d   = word_cnt_q;
      shreg_d      = shreg_q;
      xor_d        = xor_q;
      data_out_d   = data_out_q;
      word_idx_d   = word_idx_q;
      data_valid_d = 1'b0;
      frame_done_d = 1'b0;
      parity_err_d = 1'b0;

      word_next = MSB_FIRST ? DATA_W'({shreg_q, data_in})
                            : DATA_W'({data_in, shreg_q} >> 1);

      if (sync_clr) begin
         state_d    = HUNT;
         bit_cnt_d  = '0;
         word_cnt_d = '0;
         shreg_d    = '0;
         xor_d      = 1'b0;
      end else if (bit_en) begin
         unique case (state_q)
            HUNT: begin
               if (sync_match) begin
                  state_d    = RECV;
                  bit_cnt_d  = '0;
                  word_cnt_d = '0;
                  shreg_d    = '0;
                  xor_d      = 1'b0;
               end
            end
            RECV: begin
               shreg_d = word_next;
               xor_d   = xor_q ^ data_in;
               if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                  bit_cnt_d    = '0;
                  data_out_d   = word_next;
                  word_idx_d   = word_cnt_q;
                  data_valid_d = 1'b1;
                  if (word_cnt_q == IDX_W'(WORDS_PER_FRAME - 1)) begin
                     word_cnt_d = '0;
                     if (PARITY_EN) begin
                        state_d = PARITY;
                     end else begin
                        state_d      = HUNT;
                        xor_d        = 1'b0;
                        frame_done_d = 1'b1;
                     end
                  end else begin
                     word_cnt_d = word_cnt_q + IDX_W'(1);
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
            PARITY: begin
               state_d      = HUNT;
               xor_d        = 1'b0;
               frame_done_d = 1'b1;
               parity_err_d = xor_q ^ data_in;
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // NOTE: only control and datapath flops exist here, and all of them take the async reset.
   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= HUNT;
         bit_cnt_q    <= '0;
         word_cnt_q   <= '0;
         shreg_q      <= '0;
         xor_q        <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         word_idx_q   <= '0;
         frame_done_q <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         shreg_q      <= shreg_d;
         xor_q        <= xor_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         word_idx_q   <= word_idx_d;
         frame_done_q <= frame_done_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign word_idx   = word_idx_q;
   assign frame_done = frame_done_q;
   assign parity_err = parity_err_q;
   assign busy       = (state_q != HUNT);

endmodule

// File: tb/tb_frame_deserializer.sv
// Self-checking bench: frame-level model for the default receiver, directed checks for LSB-first/no-parity.
module tb_frame_deserializer;

   logic       t_clk = 1'b0;
   always #5 t_clk = ~t_clk;

   // Default-parameter receiver (MSB-first, parity on)
   logic       rst_n, data_in, bit_en, sync_clr;
   logic [7:0] data_out;
   logic       data_valid, frame_done, parity_err, busy;
   logic [1:0] word_idx;

   // LSB-first receiver without parity
   logic       b_rst_n, b_data_in, b_bit_en, b_sync_clr;
   logic [7:0] b_data_out;
   logic       b_data_valid, b_frame_done, b_parity_err, b_busy;
   logic [1:0] b_word_idx;

   frame_deserializer dut_a (
      .t_clk(t_clk), .rst_n(rst_n), .data_in(data_in), .bit_en(bit_en), .sync_clr(sync_clr),
      .data_out(data_out), .data_valid(data_valid), .word_idx(word_idx),
      .frame_done(frame_done), .parity_err(parity_err), .busy(busy)
   );

   frame_deserializer #(.MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_b (
      .t_clk(t_clk), .rst_n(b_rst_n), .data_in(b_data_in), .bit_en(b_bit_en), .sync_clr(b_sync_clr),
      .data_out(b_data_out), .data_valid(b_data_valid), .word_idx(b_word_idx),
      .frame_done(b_frame_done), .parity_err(b_parity_err), .busy(b_busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model of dut_a ----------------
   bit         hist_q[$];
   bit         fbits_q[$];
   bit         in_frame;
   logic [7:0] exp_data;
   logic [1:0] exp_idx;
   logic       exp_valid, exp_done, exp_perr, exp_busy;

   always @(posedge t_clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q.delete(); fbits_q.delete(); in_frame = 1'b0;
         exp_data = '0; exp_idx = '0; exp_valid = 0; exp_done = 0; exp_perr = 0; exp_busy = 0;
      end else begin
         exp_valid = 0; exp_done = 0; exp_perr = 0;
         if (sync_clr) begin
            hist_q.delete(); fbits_q.delete(); in_frame = 1'b0;
         end else if (bit_en) begin
            if (!in_frame) begin
               hist_q.push_back(data_in);
               if (hist_q.size() > 4) void'(hist_q.pop_front());
               if (hist_q.size() == 4 &&
                   {hist_q[0], hist_q[1], hist_q[2], hist_q[3]} == 4'b1010) begin
                  in_frame = 1'b1;
                  hist_q.delete();
               end
            end else begin
               int  n;
               bit  p;
               fbits_q.push_back(data_in);
               n = fbits_q.size();
               if (n <= 32 && n % 8 == 0) begin
                  for (int i = 0; i < 8; i++) exp_data = {exp_data[6:0], fbits_q[n-8+i]};
                  exp_idx   = 2'(n / 8 - 1);
                  exp_valid = 1;
               end
               if (n == 33) begin
                  p = 0;
                  foreach (fbits_q[i]) p ^= fbits_q[i];
                  exp_done = 1;
                  exp_perr = p;
                  fbits_q.delete();
                  in_frame = 1'b0;
               end
            end
         end
         exp_busy = in_frame;
      end
   end

   // ---------------- per-cycle compare + event log ----------------
   bit         chk_en = 0;
   logic [9:0] got_q[$];
   int         done_cnt;
   logic       last_perr;

   always @(negedge t_clk) begin
      if (chk_en && rst_n) begin
         check("data_valid", data_valid, exp_valid);
         check("frame_done", frame_done, exp_done);
         check("parity_err", parity_err, exp_perr);
         check("busy",       busy,       exp_busy);
         check("data_out",   data_out,   exp_data);
         if (exp_valid) check("word_idx", word_idx, exp_idx);
         if (data_valid) got_q.push_back({word_idx, data_out});
         if (frame_done) begin
            done_cnt++;
            last_perr = parity_err;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic d, input logic en, input logic clr);
      @(negedge t_clk);
      data_in = d; bit_en = en; sync_clr = clr;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
   endtask

   task automatic send_bits(input logic [31:0] v, input int n, input bit rnd);
      for (int i = n - 1; i >= 0; i--) begin
         if (rnd) repeat ($urandom_range(0, 2)) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
         step(v[i], 1'b1, 1'b0);
      end
   endtask

   task automatic send_frame(input logic par, input bit rnd);
      send_bits(32'hA, 4, rnd);
      send_bits(32'hA53CFF00, 32, rnd);
      send_bits({31'd0, par}, 1, rnd);
   endtask

   task automatic clear_log();
      got_q.delete();
      done_cnt  = 0;
      last_perr = 1'b0;
   endtask

   logic [7:0] ref_w [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

   task automatic expect_words(input string name, input int n);
      check({name, "_count"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++)
         check({name, "_word"}, got_q[i], {2'(i), ref_w[i]});
   endtask

   task automatic step_b(input logic d);
      @(negedge t_clk);
      b_data_in = d; b_bit_en = 1'b1;
   endtask

   task automatic send_b_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) step_b(w[i]);
   endtask

   task automatic send_b_sync();
      step_b(1); step_b(0); step_b(1); step_b(0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 0; data_in = 0; bit_en = 0; sync_clr = 0;
      b_rst_n = 0; b_data_in = 0; b_bit_en = 0; b_sync_clr = 0;
      clear_log();
      repeat (3) @(negedge t_clk);
      check("reset_a", {data_out, data_valid, word_idx, frame_done, parity_err, busy}, '0);
      check("reset_b", {b_data_out, b_data_valid, b_word_idx, b_frame_done, b_parity_err, b_busy}, '0);
      rst_n = 1; b_rst_n = 1;
      chk_en = 1;
      idle(2);

      // 1: clean frame, parity 0
      clear_log();
      send_frame(1'b0, 0); idle(3);
      expect_words("t1", 4);
      check("t1_done", done_cnt, 1);
      check("t1_perr", last_perr, 1'b0);

      // 2: wrong parity bit
      clear_log();
      send_frame(1'b1, 0); idle(3);
      expect_words("t2", 4);
      check("t2_done", done_cnt, 1);
      check("t2_perr", last_perr, 1'b1);

      // 3: sync overlapping a 1,1,0 prefix
      clear_log();
      send_bits(32'b110, 3, 0);
      send_bits(32'b10, 2, 0);
      step(0, 0, 0);
      check("t3_nothing_early", got_q.size() + done_cnt, 0);
      check("t3_busy", busy, 1'b1);
      send_bits(32'hA53CFF00, 32, 0);
      send_bits(32'd0, 1, 0); idle(3);
      expect_words("t3", 4);
      check("t3_done", done_cnt, 1);

      // 4: random bit_en gaps
      clear_log();
      send_frame(1'b0, 1); idle(3);
      expect_words("t4", 4);
      check("t4_done", done_cnt, 1);
      check("t4_perr", last_perr, 1'b0);

      // 5: abort during word 2, then a clean frame
      clear_log();
      send_bits(32'hA, 4, 0);
      send_bits(32'hA53C, 16, 0);
      send_bits(32'b111, 3, 0);
      step(1, 1, 1);
      idle(3);
      expect_words("t5_abort", 2);
      check("t5_abort_done", done_cnt, 0);
      check("t5_abort_busy", busy, 1'b0);
      clear_log();
      send_frame(1'b0, 0); idle(3);
      expect_words("t5", 4);
      check("t5_done", done_cnt, 1);

      // 6: LSB-first, no parity
      send_b_sync();
      send_b_word(8'hA5);
      @(negedge t_clk); b_bit_en = 0;
      check("t6_valid0", b_data_valid, 1'b1);
      check("t6_data0", b_data_out, 8'hA5);
      check("t6_idx0", b_word_idx, 2'd0);
      check("t6_done0", b_frame_done, 1'b0);
      send_b_word(8'h3C); send_b_word(8'hFF); send_b_word(8'h00);
      @(negedge t_clk); b_bit_en = 0;
      check("t6_valid3", b_data_valid, 1'b1);
      check("t6_idx3", b_word_idx, 2'd3);
      check("t6_data3", b_data_out, 8'h00);
      check("t6_done3", b_frame_done, 1'b1);
      check("t6_perr3", b_parity_err, 1'b0);
      check("t6_busy3", b_busy, 1'b0);
      @(negedge t_clk);
      check("t6_hold", b_data_out, 8'h00);
      check("t6_done_pulse", b_frame_done, 1'b0);

      send_b_sync();
      send_b_word(8'hA5);
      step_b(1); step_b(1); step_b(0);
      @(negedge t_clk); b_bit_en = 0;
      check("t6_mid_busy", b_busy, 1'b1);
      check("t6_mid_data", b_data_out, 8'hA5);
      #2 b_rst_n = 0;
      #1;
      check("t6_async_reset", {b_data_out, b_data_valid, b_word_idx, b_frame_done, b_parity_err, b_busy}, '0);
      @(negedge t_clk); b_rst_n = 1;

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
